// File: rtl/muldiv_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, single-cycle MULT/MULTU,
// 32-step restoring DIV/DIVU that stalls the front of the pipeline while busy.
module muldiv_unit #(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_value_i,
   input  logic [31:0] rt_value_i,
   input  logic        pipeline_stall_i,
   input  logic        flush_i,
   output logic        ex_stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q;
   logic [31:0] rem_q, quo_q, dvsr_q, rs_raw_q;
   logic [31:0] hi_q, lo_q;
   logic        q_neg_q, r_neg_q, dz_q;

   logic        is_div, is_signed;
   logic [31:0] rs_abs, rt_abs;
   logic [63:0] prod_s, prod_u;
   logic [32:0] trial;
   logic [31:0] rem_step, quo_step;
   logic        last_step;

   logic        hi_we, lo_we, div_start;
   logic [31:0] hi_d, lo_d;

   assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign is_signed = (op_i == OP_DIV);
   assign rs_abs    = (is_signed && rs_value_i[31]) ? (32'd0 - rs_value_i) : rs_value_i;
   assign rt_abs    = (is_signed && rt_value_i[31]) ? (32'd0 - rt_value_i) : rt_value_i;

   assign prod_s = $signed({{32{rs_value_i[31]}}, rs_value_i})
                 * $signed({{32{rt_value_i[31]}}, rt_value_i});
   assign prod_u = {32'd0, rs_value_i} * {32'd0, rt_value_i};

   // One restoring step: the dividend shifts out of quo_q into the remainder
   // while quotient bits shift in from the bottom.
   always_comb begin
      trial    = {rem_q, quo_q[31]} - {1'b0, dvsr_q};
      rem_step = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
      quo_step = {quo_q[30:0], ~trial[32]};
   end

   assign last_step = (cnt_q == 6'(DIV_CYCLES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (is_div)            state_d = ST_BUSY;
            ST_BUSY: if (last_step)         state_d = ST_DONE;
            ST_DONE: if (!pipeline_stall_i) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
         endcase
      end
   end

   // Output / write-enable logic
   always_comb begin
      ex_stall_o = 1'b0;
      div_start  = 1'b0;
      hi_we      = 1'b0;
      lo_we      = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      if (!rst && !flush_i) begin
         case (state_q)
            ST_IDLE: begin
               ex_stall_o = is_div;
               div_start  = is_div;
               case (op_i)
                  OP_MULT: begin
                     hi_we = 1'b1;
                     lo_we = 1'b1;
                     hi_d  = prod_s[63:32];
                     lo_d  = prod_s[31:0];
                  end
                  OP_MULTU: begin
                     hi_we = 1'b1;
                     lo_we = 1'b1;
                     hi_d  = prod_u[63:32];
                     lo_d  = prod_u[31:0];
                  end
                  OP_MTHI: begin
                     hi_we = 1'b1;
                     hi_d  = rs_value_i;
                  end
                  OP_MTLO: begin
                     lo_we = 1'b1;
                     lo_d  = rs_value_i;
                  end
                  default: ;
               endcase
            end
            ST_BUSY: begin
               ex_stall_o = 1'b1;
               if (last_step) begin
                  hi_we = 1'b1;
                  lo_we = 1'b1;
                  if (dz_q) begin
                     lo_d = '1;
                     hi_d = rs_raw_q;
                  end else begin
                     lo_d = q_neg_q ? (32'd0 - quo_step) : quo_step;
                     hi_d = r_neg_q ? (32'd0 - rem_step) : rem_step;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and architectural HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         rs_raw_q <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         if (hi_we) hi_q <= hi_d;
         if (lo_we) lo_q <= lo_d;
         if (div_start) begin
            rem_q    <= '0;
            quo_q    <= rs_abs;
            dvsr_q   <= rt_abs;
            rs_raw_q <= rs_value_i;
            dz_q     <= (rt_value_i == 32'd0);
            q_neg_q  <= (rs_value_i[31] ^ rt_value_i[31]) & is_signed & (rt_value_i != 32'd0);
            r_neg_q  <= rs_value_i[31] & is_signed;
            cnt_q    <= '0;
         end else if (state_q == ST_BUSY && !flush_i) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 6'd1;
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  op_i;
   logic [31:0] rs_value_i, rt_value_i;
   logic        pipeline_stall_i, flush_i;
   logic        ex_stall_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.DIV_CYCLES(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .op_i             (op_i),
      .rs_value_i       (rs_value_i),
      .rt_value_i       (rt_value_i),
      .pipeline_stall_i (pipeline_stall_i),
      .flush_i          (flush_i),
      .ex_stall_o       (ex_stall_o),
      .hi_o             (hi_o),
      .lo_o             (lo_o)
   );

   always #5 clk = ~clk;

   function automatic void ref_div(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] lo, output logic [31:0] hi);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         lo = '1;
         hi = a;
      end else if (op == OP_DIV) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         lo = q[31:0];
         hi = r[31:0];
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint p;
      if (op == OP_MULT) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return p;
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic test_reset();
      rst = 1'b1; op_i = OP_DIV; rs_value_i = 32'd100; rt_value_i = 32'd7;
      repeat (2) begin
         @(negedge clk); #1;
         checks++;
         if (ex_stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", ex_stall_o);
         end
      end
      checks++;
      if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
         errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi_o, lo_o);
      end
      @(negedge clk);
      rst = 1'b0; op_i = OP_NONE;
      repeat (3) begin
         #1;
         checks++;
         if (ex_stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_no_launch got %b exp 0", ex_stall_o);
         end
         @(negedge clk);
      end
   endtask

   task automatic do_mult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp_p;
      exp_p = ref_mul(op, a, b);
      op_i = op; rs_value_i = a; rt_value_i = b;
      #1;
      checks++;
      if (ex_stall_o !== 1'b0) begin
         errors++; $display("FAIL mult_stall got %b exp 0", ex_stall_o);
      end
      @(posedge clk); #1;
      checks++;
      if (hi_o !== exp_p[63:32] || lo_o !== exp_p[31:0]) begin
         errors++;
         $display("FAIL mult op=%0d a=%h b=%h got %h_%h exp %h_%h",
                  op, a, b, hi_o, lo_o, exp_p[63:32], exp_p[31:0]);
      end
      @(negedge clk);
      op_i = OP_NONE;
   endtask

   task automatic test_mult();
      do_mult(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
      do_mult(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      do_mult(OP_MULT,  32'h8000_0000, 32'h8000_0000);
      for (int i = 0; i < 8; i++)
         do_mult(($urandom_range(0, 1) != 0) ? OP_MULT : OP_MULTU, $urandom, $urandom);
   endtask

   task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
      op_i = OP_MTHI; rs_value_i = h;
      @(negedge clk);
      op_i = OP_MTLO; rs_value_i = l;
      @(negedge clk);
      op_i = OP_NONE;
      #1;
      checks++;
      if (hi_o !== h || lo_o !== l) begin
         errors++; $display("FAIL mthi_mtlo got %h/%h exp %h/%h", hi_o, lo_o, h, l);
      end
   endtask

   // Starts a divide in the current cycle, counts stall cycles up to DONE,
   // optionally holds DONE, and returns just after the DONE cycle ends.
   task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit rand_ps, input int hold);
      logic [31:0] exp_lo, exp_hi;
      int n;
      ref_div(op, a, b, exp_lo, exp_hi);
      op_i = op; rs_value_i = a; rt_value_i = b; pipeline_stall_i = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!ex_stall_o) break;
         n++;
         @(negedge clk);
         if (rand_ps) pipeline_stall_i = ($urandom_range(0, 1) != 0);
         rs_value_i = $urandom;
         rt_value_i = $urandom;
      end
      checks++;
      if (n != 33) begin
         errors++; $display("FAIL div_stall_cycles a=%h b=%h got %0d exp 33", a, b, n);
      end
      checks++;
      if (hi_o !== exp_hi || lo_o !== exp_lo) begin
         errors++;
         $display("FAIL div op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                  op, a, b, hi_o, lo_o, exp_hi, exp_lo);
      end
      pipeline_stall_i = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         checks++;
         if (ex_stall_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
            errors++;
            $display("FAIL div_hold cyc=%0d got stall=%b hi=%h lo=%h exp stall=0 hi=%h lo=%h",
                     i, ex_stall_o, hi_o, lo_o, exp_hi, exp_lo);
         end
         if (i == hold - 1) pipeline_stall_i = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_div();
      run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      op_i = OP_NONE; @(negedge clk);
      run_div(OP_DIVU, 32'd100, 32'd7, 1'b1, 0);
      op_i = OP_NONE; @(negedge clk);
   endtask

   task automatic test_corners();
      run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      op_i = OP_NONE; @(negedge clk);
      run_div(OP_DIVU, 32'd5, 32'd0, 1'b0, 0);
      op_i = OP_NONE; @(negedge clk);
      run_div(OP_DIV,  32'hFFFF_FFF0, 32'd0, 1'b0, 0);
      op_i = OP_NONE; @(negedge clk);
   endtask

   task automatic test_held_done();
      run_div(OP_DIVU, 32'd9, 32'd4, 1'b0, 5);
      op_i = OP_NONE;
      #1;
      checks++;
      if (ex_stall_o !== 1'b0 || hi_o !== 32'd1 || lo_o !== 32'd2) begin
         errors++;
         $display("FAIL held_release got stall=%b hi=%h lo=%h exp 0/1/2", ex_stall_o, hi_o, lo_o);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic [2:0]  op;
      for (int i = 0; i < 10; i++) begin
         op = ($urandom_range(0, 1) != 0) ? OP_DIV : OP_DIVU;
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         run_div(op, a, b, 1'b1, 0);
      end
      op_i = OP_NONE;
      @(negedge clk);
   endtask

   task automatic test_flush(input bit use_rst);
      logic [31:0] exp_v;
      exp_v = use_rst ? 32'd0 : 32'hA5A5_A5A5;
      set_hilo(32'hA5A5_A5A5, 32'hA5A5_A5A5);
      @(negedge clk);
      op_i = OP_DIVU; rs_value_i = 32'd100; rt_value_i = 32'd7;
      #1;
      checks++;
      if (ex_stall_o !== 1'b1) begin
         errors++; $display("FAIL flush_accept_stall got %b exp 1", ex_stall_o);
      end
      repeat (10) @(negedge clk);
      if (use_rst) rst = 1'b1;
      else         flush_i = 1'b1;
      #1;
      checks++;
      if (ex_stall_o !== 1'b0) begin
         errors++; $display("FAIL flush_cycle_stall rst=%0d got %b exp 0", use_rst, ex_stall_o);
      end
      @(negedge clk);
      rst = 1'b0; flush_i = 1'b0; op_i = OP_NONE;
      #1;
      checks++;
      if (ex_stall_o !== 1'b0 || hi_o !== exp_v || lo_o !== exp_v) begin
         errors++;
         $display("FAIL flush_after rst=%0d got stall=%b hi=%h lo=%h exp 0/%h/%h",
                  use_rst, ex_stall_o, hi_o, lo_o, exp_v, exp_v);
      end
      repeat (40) @(negedge clk);
      #1;
      checks++;
      if (hi_o !== exp_v || lo_o !== exp_v) begin
         errors++;
         $display("FAIL flush_late_write rst=%0d got hi=%h lo=%h exp %h", use_rst, hi_o, lo_o, exp_v);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; op_i = OP_NONE; rs_value_i = '0; rt_value_i = '0;
      pipeline_stall_i = 1'b0; flush_i = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_corners();
      test_held_done();
      test_back_to_back();
      test_flush(1'b0);
      test_flush(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multiply/divide execution unit for the EX stage of the five-stage pipeline. It owns the architectural HI/LO registers and executes MULT/MULTU in one cycle and DIV/DIVU iteratively, one quotient bit per cycle. While a divide is in flight it raises `ex_stall_o`, which drives the `ex_stall_i` input of the pipeline stall controller. It also observes the frozen-pipeline condition so that a held instruction is never launched twice.

## Interface
Parameters:
- `DIV_CYCLES`, 32: number of iteration cycles. Fixed at 32 for 32-bit operands and not intended to be changed.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `op_i`  in  3  operation of the instruction in EX: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- `rs_value_i`  in  32  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source)
- `rt_value_i`  in  32  forwarded rt operand (divisor / multiplier)
- `pipeline_stall_i`  in  1  ID/EX register held this cycle (the stall controller's `id_ex_stall_o`)
- `flush_i`  in  1  exception/flush; kills the EX instruction
- `ex_stall_o`  out  1  EX busy; request to freeze IF/ID
- `hi_o`  out  32  HI register
- `lo_o`  out  32  LO register

## Operation
- States: IDLE, BUSY, DONE. A 6-bit iteration counter is used in BUSY.
- **IDLE:**
  - MULT/MULTU (no flush): {HI,LO} ← 64-bit signed/unsigned product, written at this edge. No stall.
  - MTHI: HI ← rs. MTLO: LO ← rs.
  - These writes repeat while the instruction is held. They are idempotent.
- **IDLE, DIV/DIVU (no flush):**
  - Latch absolute values: signed ops only; DIVU uses raw operands.
  - Latch quotient sign = (rs[31]^rt[31]) & signed & (rt≠0), and remainder sign = rs[31] & signed.
  - Latch a divisor-zero flag and the raw rs value.
  - Clear the partial remainder and the counter. Go to BUSY.
- **BUSY:**
  - Each cycle, perform one restoring step: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient LSB to 1 if the result is non-negative, and increment the counter.
  - On the 32nd step, write HI/LO at that edge and go to DONE:
    - Normal case: LO ← quotient, negated if the quotient sign is set. HI ← remainder, negated if the remainder sign is set.
    - Divisor zero: LO ← 0xFFFFFFFF and HI ← latched rs. The full latency still applies.
  - Operand inputs are ignored while in BUSY.
- **DONE:**
  - The DIV is still on `op_i`. It is not relaunched.
  - Stay in DONE while `pipeline_stall_i`=1. Go to IDLE at the first edge where `pipeline_stall_i`=0.
- **`flush_i`:** from any state, go to IDLE at the next edge. HI/LO are not written in a cycle where `flush_i`=1. Any partial divide is discarded.
- **`ex_stall_o`** = !rst & !flush_i & ((IDLE & op_i∈{DIV,DIVU}) | BUSY). It is combinational and is 0 in DONE.
- **Arithmetic:**
  - Negation is two's complement mod 2^32.
  - 0x80000000 / 0xFFFFFFFF (signed) yields LO=0x80000000, HI=0.

## Timing
- **Reset:** `rst` high at an edge sets state=IDLE, counter=0, `hi_o`=`lo_o`=0. `ex_stall_o`=0 while `rst`=1.
  - Reset mid-divide aborts the divide. No partial result is written.
- **Multiply:** the result is visible on `hi_o`/`lo_o` in the cycle after acceptance, so a following MFHI/MFLO in EX reads it with no bubble.
- **Divide:**
  - Accepted in cycle N. BUSY for cycles N+1..N+32. `ex_stall_o`=1 for cycles N..N+32, exactly 33 cycles.
  - HI/LO are valid from cycle N+33 (DONE), where `ex_stall_o`=0.
  - The DIV leaves EX at the end of the first DONE cycle with `pipeline_stall_i`=0.
- **Back-to-back DIVs:** the second is accepted in the cycle after the first leaves DONE.
- **Simultaneous events:**
  - `pipeline_stall_i` during BUSY has no effect; iteration continues.
  - `flush_i` has priority over all other behaviour.
  - `rst` has priority over `flush_i`.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `op_i`=DIV → `hi_o`=`lo_o`=0, `ex_stall_o`=0, and no divide starts after release unless `op_i` is still DIV.
- **Multiply:**
  - MULT 0xFFFFFFFF×0x00000002 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE, `ex_stall_o` never 1.
  - MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **Divide:**
  - DIV −7/2 → `ex_stall_o` high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 → LO=14, HI=2.
- **Corner cases:**
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5, still 33 stall cycles.
- **Held completion:** DIVU 9/4 completes with `pipeline_stall_i`=1 for 5 more cycles → unit stays in DONE, `ex_stall_o`=0, HI=1/LO=2 unchanged, and no second launch.
- **Flush:**
  - Start DIVU 100/7 with HI=LO=0xA5A5A5A5, then assert `flush_i` in BUSY cycle 10 → `ex_stall_o`=0 that cycle, IDLE next, HI/LO remain 0xA5A5A5A5.
  - Repeat with `rst` instead → HI/LO=0.
